// File: rtl/vending_pkg.sv
// Shared constants for the vending change dispenser: FSM state encoding and
// coin values expressed in 25 kr units.
package vending_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_SELECT = 3'd2;
    localparam logic [2:0] S_EJ50   = 3'd3;
    localparam logic [2:0] S_EJ25   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;

    localparam int unsigned COIN_25 = 1;
    localparam int unsigned COIN_50 = 2;

endpackage

// File: rtl/vending_change_dispenser.sv
// Change dispenser: latches credit/price, then pays out the difference one coin
// at a time, preferring 50 kr coins while that hopper has stock.
//
// state  | meaning
// IDLE   | waiting for start; credit and price latched on start
// CALC   | compare credit with price, load remaining change
// SELECT | choose next coin (50 if possible, else 25) or finish
// EJ50   | request one 50 kr coin until hopper_ack
// EJ25   | request one 25 kr coin until hopper_ack
// DONE   | one-cycle done pulse
// FAIL   | one-cycle error pulse, credit was short
module vending_change_dispenser
    import vending_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] credit,
    input  logic [W-1:0] price,
    input  logic         stock_50_empty,
    input  logic         hopper_ack,
    output logic         coin_25_out,
    output logic         coin_50_out,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [W-1:0] C25 = W'(COIN_25);
    localparam logic [W-1:0] C50 = W'(COIN_50);

    logic [2:0]   state_q, state_d;
    logic [W-1:0] credit_q, credit_d;
    logic [W-1:0] price_q, price_d;
    logic [W-1:0] remaining_q, remaining_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            price_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            price_q     <= price_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        price_d     = price_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    credit_d = credit;
                    price_d  = price;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (credit_q < price_q) begin
                    state_d = S_FAIL;
                end else begin
                    remaining_d = credit_q - price_q;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                // An empty 50 hopper falls back to 25s for the whole remainder.
                if (remaining_q >= C50 && !stock_50_empty) begin
                    state_d = S_EJ50;
                end else if (remaining_q >= C25) begin
                    state_d = S_EJ25;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_EJ50: begin
                if (hopper_ack) begin
                    remaining_d = remaining_q - C50;
                    state_d     = S_SELECT;
                end
            end
            S_EJ25: begin
                if (hopper_ack) begin
                    remaining_d = remaining_q - C25;
                    state_d     = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: reset forces IDLE, which clears every output at once.
    always_comb begin
        coin_25_out = (state_q == S_EJ25);
        coin_50_out = (state_q == S_EJ50);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        error       = (state_q == S_FAIL);
    end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Randomized bench for vending_change_dispenser with a greedy payout model.
module tb_vending_change_dispenser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] credit;
    logic [W-1:0] price;
    logic         stock_50_empty;
    logic         hopper_ack;
    logic         coin_25_out;
    logic         coin_50_out;
    logic         busy;
    logic         done;
    logic         error;

    int n_pass  = 0;
    int n_total = 0;

    vending_change_dispenser #(.W(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .credit         (credit),
        .price          (price),
        .stock_50_empty (stock_50_empty),
        .hopper_ack     (hopper_ack),
        .coin_25_out    (coin_25_out),
        .coin_50_out    (coin_50_out),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Coin sequence as base-3 digits (1 = 25 kr, 2 = 50 kr), oldest coin first.
    function automatic int model_code(input int c, input int p, input bit no50,
                                      output bit err);
        int rem;
        int code;
        code = 0;
        err  = (c < p);
        if (err) return 0;
        rem = c - p;
        while (rem > 0) begin
            if (rem >= 2 && !no50) begin
                code = code * 3 + 2;
                rem  = rem - 2;
            end else begin
                code = code * 3 + 1;
                rem  = rem - 1;
            end
        end
        return code;
    endfunction

    task automatic run_txn(input int c, input int p, input bit no50,
                           input int max_dly, input int hold);
        int  code, exp_code, term_k, term_kind, both, busy_gap, wait_cnt, dly, exp_lat;
        bit  exp_err, prev_coin, cur_coin;
        code      = 0;
        term_k    = -1;
        term_kind = 0;
        both      = 0;
        busy_gap  = 0;
        wait_cnt  = 0;
        prev_coin = 1'b0;
        exp_code  = model_code(c, p, no50, exp_err);
        exp_lat   = exp_err ? 2 : ((c == p) ? 3 : -1);

        @(negedge clk);
        credit         = W'(c);
        price          = W'(p);
        stock_50_empty = no50;
        start          = 1'b1;
        hopper_ack     = 1'b0;
        dly            = $urandom_range(max_dly, 0);

        for (int k = 1; k <= 400 && term_k < 0; k++) begin
            @(negedge clk);
            start = (k < hold);
            if (start) begin
                credit = W'($urandom_range(15, 0));
                price  = W'($urandom_range(15, 0));
            end
            if (coin_25_out && coin_50_out) both++;
            if (!busy) busy_gap++;
            cur_coin = coin_25_out | coin_50_out;
            if (coin_50_out && !prev_coin) code = code * 3 + 2;
            else if (coin_25_out && !prev_coin) code = code * 3 + 1;
            prev_coin = cur_coin;
            if (done || error) begin
                term_k    = k;
                term_kind = error ? 2 : 1;
            end
            if (cur_coin) begin
                hopper_ack = (wait_cnt == dly);
                if (wait_cnt == dly) begin
                    wait_cnt = 0;
                    dly      = $urandom_range(max_dly, 0);
                end else begin
                    wait_cnt++;
                end
            end else begin
                hopper_ack = 1'($urandom_range(1, 0));
            end
        end

        check($sformatf("end_kind c=%0d p=%0d", c, p), term_kind, exp_err ? 2 : 1);
        check($sformatf("coin_seq c=%0d p=%0d no50=%0d", c, p, no50), code, exp_code);
        check("coins_overlap", both, 0);
        check("busy_gap", busy_gap, 0);
        if (exp_lat >= 0)
            check($sformatf("latency c=%0d p=%0d", c, p), term_k, exp_lat);
        @(negedge clk);
        hopper_ack = 1'b0;
        check("busy_after", busy, 0);
        check("pulse_after", done | error, 0);
    endtask

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        credit         = '0;
        price          = '0;
        stock_50_empty = 1'b0;
        hopper_ack     = 1'b0;
        #12;
        check("rst_coin25", coin_25_out, 0);
        check("rst_coin50", coin_50_out, 0);
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_error",  error, 0);
        @(negedge clk);
        reset = 1'b1;

        run_txn(8, 4, 1'b0, 1, 1);
        run_txn(7, 4, 1'b0, 1, 1);
        run_txn(6, 4, 1'b1, 1, 1);
        run_txn(3, 4, 1'b0, 1, 1);
        run_txn(4, 4, 1'b0, 1, 3);

        // Reset in the middle of a 50 kr ejection with no ack.
        @(negedge clk);
        credit         = W'(15);
        price          = W'(1);
        stock_50_empty = 1'b0;
        hopper_ack     = 1'b0;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ej50_before_reset", coin_50_out, 1);
        #2 reset = 1'b0;
        #1;
        check("reset_coin50", coin_50_out, 0);
        check("reset_coin25", coin_25_out, 0);
        check("reset_busy",   busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", busy, 0);
        run_txn(5, 4, 1'b0, 2, 1);

        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(15, 0), $urandom_range(15, 0),
                    1'($urandom_range(1, 0)), $urandom_range(3, 0),
                    $urandom_range(2, 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
